// File: rtl/uart_rx_if.sv
// Serial-receive bundle: the raw RX line into the receiver, received byte plus strobe out.
// The master modport is the receiver side; the slave modport is the line driver / byte consumer.
interface uart_rx_if;
    logic       i_uart_rx;
    logic [7:0] o_uart_data;
    logic       o_data_valid;

    modport master (
        input  i_uart_rx,
        output o_uart_data,
        output o_data_valid
    );

    modport slave (
        output i_uart_rx,
        input  o_uart_data,
        input  o_data_valid
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 or 8E1/8O1; one-cycle strobe per good frame. Optional macro UART_RX_MAJORITY_EN.
// Latency: strobe 2-3 clk after mid-stop-bit (plus 1 clk with majority voting).
// No backpressure: the consumer must take each byte on its strobe; o_uart_data holds until the next good frame.
module uart_rx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int EN_PARITY  = 11
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.master bus
);
    localparam int BIT_CYC = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int DEC_CNT = BIT_CYC / 2 + 1;
`else
    localparam int DEC_CNT = BIT_CYC / 2;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(DEC_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit PAR_EN  = (EN_PARITY == 10) || (EN_PARITY == 11);
    localparam bit PAR_ODD = (EN_PARITY == 11);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           r_state;
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shreg;
    logic             r_perr;
    logic [7:0]       r_data;
    logic             r_vld;

    logic w_rx_s;
    logic w_bit;
    logic w_at_dec;
    logic w_at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], bus.i_uart_rx};
        end
    end

    assign w_rx_s = r_sync[1];

`ifdef UART_RX_MAJORITY_EN
    // r_hist holds rx_s from the two preceding counts, so at DEC_CNT the vote covers mid-1, mid, mid+1.
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    assign w_at_dec  = (r_cnt == CNT_DEC);
    assign w_at_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_perr    <= 1'b0;
            r_data    <= 8'h00;
            r_vld     <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            r_cnt <= w_at_last ? '0 : r_cnt + CNT_ONE;
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    r_perr    <= 1'b0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                    end
                end
                // Hold through the rest of the start bit so DATA counts restart on a bit boundary.
                S_START: begin
                    if (w_at_dec && w_bit) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_at_last) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                    end
                end
                S_DATA: begin
                    if (w_at_dec) begin
                        r_shreg[r_bit_idx] <= w_bit;
                    end
                    if (w_at_last) begin
                        r_cnt     <= '0;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= PAR_EN ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_at_dec) begin
                        r_perr <= (w_bit != (PAR_ODD ? ~^r_shreg : ^r_shreg));
                    end
                    if (w_at_last) begin
                        r_state <= S_STOP;
                        r_cnt   <= '0;
                    end
                end
                // Leave at mid-stop so a back-to-back start edge is not missed.
                S_STOP: begin
                    if (w_at_dec) begin
                        if (w_bit && !r_perr) begin
                            r_data <= r_shreg;
                            r_vld  <= 1'b1;
                        end
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.o_uart_data  = r_data;
    assign bus.o_data_valid = r_vld;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: odd, even and no-parity instances share one clock; expected bytes are queued
// at stimulus time and popped by per-instance monitors on each strobe.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CF  = 1_600_000;
    localparam int BR  = 100_000;
    localparam int BIT = CF / BR;

    logic       clk = 1'b0;
    logic [2:0] rst_n;

    always #10 clk = ~clk;

    uart_rx_if if0 ();
    uart_rx_if if1 ();
    uart_rx_if if2 ();

    uart_rx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .EN_PARITY(11)) dut_odd (
        .clk(clk), .rst_n(rst_n[0]), .bus(if0.master));
    uart_rx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .EN_PARITY(10)) dut_even (
        .clk(clk), .rst_n(rst_n[1]), .bus(if1.master));
    uart_rx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .EN_PARITY(0)) dut_none (
        .clk(clk), .rst_n(rst_n[2]), .bus(if2.master));

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [7:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: strobe with data %h, expected no strobe", name, act);
    endtask

    always @(negedge clk) begin
        if (if0.o_data_valid === 1'b1) begin
            if (q0.size() == 0) unexpected("odd_strobe", if0.o_uart_data);
            else check8("odd_data", if0.o_uart_data, q0.pop_front());
        end
        if (if1.o_data_valid === 1'b1) begin
            if (q1.size() == 0) unexpected("even_strobe", if1.o_uart_data);
            else check8("even_data", if1.o_uart_data, q1.pop_front());
        end
        if (if2.o_data_valid === 1'b1) begin
            if (q2.size() == 0) unexpected("none_strobe", if2.o_uart_data);
            else check8("none_data", if2.o_uart_data, q2.pop_front());
        end
    end

    task automatic set_line(input int inst, input logic b);
        case (inst)
            0:       if0.i_uart_rx = b;
            1:       if1.i_uart_rx = b;
            default: if2.i_uart_rx = b;
        endcase
    endtask

    task automatic push(input int inst, input logic [7:0] d);
        case (inst)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic get_data(input int inst, output logic [7:0] d);
        case (inst)
            0:       d = if0.o_uart_data;
            1:       d = if1.o_uart_data;
            default: d = if2.o_uart_data;
        endcase
    endtask

    task automatic check_drained(input int inst, input string name);
        int sz;
        case (inst)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        n_chk++;
        if (sz != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected strobes missing, expected 0", name, sz);
        end
    endtask

    task automatic check_hold(input int inst, input string name, input logic [7:0] exp);
        logic [7:0] d;
        get_data(inst, d);
        check8(name, d, exp);
    endtask

    task automatic send_bit(input int inst, input logic b);
        set_line(inst, b);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic idle_bits(input int inst, input int n);
        set_line(inst, 1'b1);
        repeat (n * BIT) @(negedge clk);
    endtask

    task automatic send_frame(input int inst, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop);
        send_bit(inst, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(inst, d[i]);
        if (has_par) send_bit(inst, par);
        send_bit(inst, stop);
        set_line(inst, 1'b1);
    endtask

    // Good 0xA5, back-to-back good 0x0E, then a bad 0x3C frame that must be dropped.
    task automatic run_basic(input int inst, input string tag, input logic has_par,
                             input logic p_a5, input logic p_0e, input logic p_bad,
                             input logic stop_bad);
        push(inst, 8'hA5);
        send_frame(inst, 8'hA5, has_par, p_a5, 1'b1);
        push(inst, 8'h0E);
        send_frame(inst, 8'h0E, has_par, p_0e, 1'b1);
        idle_bits(inst, 2);
        check_drained(inst, {tag, "_s12_count"});
        check_hold(inst, {tag, "_s12_hold"}, 8'h0E);
        send_frame(inst, 8'h3C, has_par, p_bad, stop_bad);
        idle_bits(inst, 2);
        check_drained(inst, {tag, "_s3_count"});
        check_hold(inst, {tag, "_s3_hold"}, 8'h0E);
    endtask

    logic [7:0] pat;

    initial begin
        rst_n = 3'b000;
        if0.i_uart_rx = 1'b1;
        if1.i_uart_rx = 1'b1;
        if2.i_uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check8("rst_odd_data",  if0.o_uart_data, 8'h00);
        check8("rst_even_data", if1.o_uart_data, 8'h00);
        check8("rst_none_data", if2.o_uart_data, 8'h00);
        check8("rst_odd_vld",  {7'd0, if0.o_data_valid}, 8'h00);
        check8("rst_even_vld", {7'd0, if1.o_data_valid}, 8'h00);
        check8("rst_none_vld", {7'd0, if2.o_data_valid}, 8'h00);
        rst_n = 3'b111;
        idle_bits(0, 2);

        // Odd parity: A5 -> 1, 0E -> 0; 3C needs 1, so 0 is wrong.
        run_basic(0, "odd", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // 3-cycle low glitch (well under half a bit) must be filtered.
        set_line(0, 1'b0);
        repeat (3) @(negedge clk);
        idle_bits(0, 2);
        check_drained(0, "odd_glitch_count");
        push(0, 8'h5A);
        send_frame(0, 8'h5A, 1'b1, 1'b1, 1'b1);
        idle_bits(0, 2);
        check_drained(0, "odd_s4_count");
        check_hold(0, "odd_s4_hold", 8'h5A);

        send_frame(0, 8'h81, 1'b1, 1'b1, 1'b0);
        idle_bits(0, 2);
        check_drained(0, "odd_framing_count");
        check_hold(0, "odd_framing_hold", 8'h5A);
        push(0, 8'h81);
        send_frame(0, 8'h81, 1'b1, 1'b1, 1'b1);
        idle_bits(0, 2);
        check_drained(0, "odd_s5_count");
        check_hold(0, "odd_s5_hold", 8'h81);

        // Reset in the middle of data bit 4 of 0xF0; remaining bits are all 1 so no false start.
        pat = 8'hF0;
        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, pat[i]);
        set_line(0, pat[4]);
        repeat (BIT / 2) @(negedge clk);
        rst_n[0] = 1'b0;
        repeat (2) @(negedge clk);
        check_hold(0, "odd_midreset_data", 8'h00);
        rst_n[0] = 1'b1;
        repeat (BIT - BIT / 2 - 2) @(negedge clk);
        for (int i = 5; i < 8; i++) send_bit(0, pat[i]);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        idle_bits(0, 2);
        check_drained(0, "odd_s6_count");
        check_hold(0, "odd_s6_hold", 8'h00);
        push(0, 8'hFF);
        send_frame(0, 8'hFF, 1'b1, 1'b1, 1'b1);
        idle_bits(0, 2);
        check_drained(0, "odd_s6b_count");
        check_hold(0, "odd_s6b_hold", 8'hFF);

        // Even parity: A5 -> 0, 0E -> 1; 3C needs 0, so 1 is wrong.
        run_basic(1, "even", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

        // No parity: the bad 0x3C frame carries a 0 stop bit instead.
        run_basic(2, "none", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
